ext_addr_decoder: RTL and testbench

EXT_ADDR_DECODER -- requirements
Module: ext_addr_decoder

---
 rtl/ext_addr_decoder.sv | 144 ++++++++++++++
 tb/tb_ext_addr_decoder.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ext_addr_decoder.sv
// Programmable address-range decoder: lockable rule table, one-deep registered
// result stage with valid/ready handshake, and a saturating miss counter.
module ext_addr_decoder #(
    parameter  int NRULES = 4,
    parameter  int ADDR_W = 32,
    parameter  int IDX_W  = 4,
    localparam int SEL_W  = (NRULES > 1) ? $clog2(NRULES) : 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cfg_we_i,
    input  logic [SEL_W-1:0]  cfg_sel_i,
    input  logic [ADDR_W-1:0] cfg_start_i,
    input  logic [ADDR_W-1:0] cfg_end_i,
    input  logic [IDX_W-1:0]  cfg_idx_i,
    input  logic              cfg_en_i,
    input  logic              cfg_lock_i,
    output logic              cfg_err_o,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [ADDR_W-1:0] req_addr_i,
    output logic              dec_valid_o,
    input  logic              dec_ready_i,
    output logic [ADDR_W-1:0] dec_addr_o,
    output logic [IDX_W-1:0]  dec_idx_o,
    output logic              dec_hit_o,
    output logic              dec_multi_o,
    output logic [15:0]       miss_cnt_o
);

    typedef enum logic {
        ST_UNLOCKED,
        ST_LOCKED
    } cfg_state_t;

    cfg_state_t        r_state;
    logic [ADDR_W-1:0] r_start [NRULES];
    logic [ADDR_W-1:0] r_end   [NRULES];
    logic [IDX_W-1:0]  r_idx   [NRULES];
    logic [NRULES-1:0] r_en;
    logic              r_cfg_err;

    logic              r_dec_valid;
    logic [ADDR_W-1:0] r_dec_addr;
    logic [IDX_W-1:0]  r_dec_idx;
    logic              r_dec_hit;
    logic              r_dec_multi;
    logic [15:0]       r_miss_cnt;

    logic              w_sel_ok;
    logic              w_wr_ok;
    logic              w_accept;
    logic [NRULES-1:0] w_match;
    logic              w_hit;
    logic              w_multi;
    logic [IDX_W-1:0]  w_idx;

    assign w_sel_ok = ({1'b0, cfg_sel_i} < (SEL_W + 1)'(NRULES));
    assign w_wr_ok  = cfg_we_i && (r_state == ST_UNLOCKED) && w_sel_ok;

    // A write coinciding with the lock pulse still sees ST_UNLOCKED and lands.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= ST_UNLOCKED;
            r_cfg_err <= 1'b0;
            r_en      <= '0;
            // NOTE: the rule table is reset too, so a fresh part can never hit on stale ranges.
            for (int k = 0; k < NRULES; k++) begin
                r_start[k] <= '0;
                r_end[k]   <= '0;
                r_idx[k]   <= '0;
            end
        end else begin
            // NOTE: non-blocking everywhere here so every read sees the pre-edge table.
            r_cfg_err <= cfg_we_i && !w_wr_ok;
            if (w_wr_ok) begin
                r_start[cfg_sel_i] <= cfg_start_i;
                r_end[cfg_sel_i]   <= cfg_end_i;
                r_idx[cfg_sel_i]   <= cfg_idx_i;
                r_en[cfg_sel_i]    <= cfg_en_i;
            end
            case (r_state)
                ST_UNLOCKED: if (cfg_lock_i) r_state <= ST_LOCKED;
                ST_LOCKED:   r_state <= ST_LOCKED;
                default:     r_state <= ST_LOCKED;
            endcase
        end
    end

    // Empty or inverted ranges (start >= end) fall out of the compare naturally.
    always_comb begin
        w_match = '0;
        for (int k = 0; k < NRULES; k++) begin
            w_match[k] = r_en[k] && (req_addr_i >= r_start[k]) && (req_addr_i < r_end[k]);
        end
    end

    // NOTE: every comb output gets a default first, so no latch is inferred.
    always_comb begin
        w_hit = 1'b0;
        w_idx = '0;
        for (int k = NRULES - 1; k >= 0; k--) begin
            if (w_match[k]) begin
                w_hit = 1'b1;
                w_idx = r_idx[k];
            end
        end
        w_multi = (w_match & (w_match - NRULES'(1))) != '0;
    end

    assign req_ready_o = !r_dec_valid || dec_ready_i;
    assign w_accept    = req_valid_i && req_ready_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_dec_valid <= 1'b0;
            r_dec_addr  <= '0;
            r_dec_idx   <= '0;
            r_dec_hit   <= 1'b0;
            r_dec_multi <= 1'b0;
            r_miss_cnt  <= '0;
        end else if (w_accept) begin
            r_dec_valid <= 1'b1;
            r_dec_addr  <= req_addr_i;
            r_dec_idx   <= w_idx;
            r_dec_hit   <= w_hit;
            r_dec_multi <= w_multi;
            if (!w_hit && (r_miss_cnt != 16'hFFFF)) begin
                r_miss_cnt <= r_miss_cnt + 16'd1;
            end
        end else if (dec_ready_i) begin
            r_dec_valid <= 1'b0;
        end
    end

    assign cfg_err_o   = r_cfg_err;
    assign dec_valid_o = r_dec_valid;
    assign dec_addr_o  = r_dec_addr;
    assign dec_idx_o   = r_dec_idx;
    assign dec_hit_o   = r_dec_hit;
    assign dec_multi_o = r_dec_multi;
    assign miss_cnt_o  = r_miss_cnt;

endmodule

// File: tb/tb_ext_addr_decoder.sv
// Scoreboard bench for ext_addr_decoder: directed requests push expected results,
// a negedge monitor pops and compares on every result handshake.
module tb_ext_addr_decoder;

    localparam int NRULES = 3;

    typedef struct {
        logic [31:0] addr;
        logic        hit;
        logic [3:0]  idx;
        logic        multi;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_sel = '0;
    logic [31:0] cfg_start = '0;
    logic [31:0] cfg_end = '0;
    logic [3:0]  cfg_idx = '0;
    logic        cfg_en = 1'b0;
    logic        cfg_lock = 1'b0;
    logic        req_valid = 1'b0;
    logic [31:0] req_addr = '0;
    logic        dec_ready = 1'b1;

    logic        cfg_err_o;
    logic        req_ready_o;
    logic        dec_valid_o;
    logic [31:0] dec_addr_o;
    logic [3:0]  dec_idx_o;
    logic        dec_hit_o;
    logic        dec_multi_o;
    logic [15:0] miss_cnt_o;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    longint t0;

    ext_addr_decoder #(.NRULES(NRULES), .ADDR_W(32), .IDX_W(4)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .cfg_we_i    (cfg_we),
        .cfg_sel_i   (cfg_sel),
        .cfg_start_i (cfg_start),
        .cfg_end_i   (cfg_end),
        .cfg_idx_i   (cfg_idx),
        .cfg_en_i    (cfg_en),
        .cfg_lock_i  (cfg_lock),
        .cfg_err_o   (cfg_err_o),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready_o),
        .req_addr_i  (req_addr),
        .dec_valid_o (dec_valid_o),
        .dec_ready_i (dec_ready),
        .dec_addr_o  (dec_addr_o),
        .dec_idx_o   (dec_idx_o),
        .dec_hit_o   (dec_hit_o),
        .dec_multi_o (dec_multi_o),
        .miss_cnt_o  (miss_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [31:0] a, input logic h, input logic [3:0] ix, input logic m);
        exp_t e;
        e.addr = a; e.hit = h; e.idx = ix; e.multi = m;
        exp_q.push_back(e);
    endtask

    // Entered just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [31:0] a, input logic h, input logic [3:0] ix, input logic m);
        int n = 0;
        req_valid = 1'b1;
        req_addr  = a;
        while (!req_ready_o && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("req_ready_wait", req_ready_o, 1);
        push(a, h, ix, m);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wr(input logic [1:0] sel, input logic [31:0] s, input logic [31:0] e,
                      input logic [3:0] ix, input logic en, input logic lk, input logic err);
        cfg_we = 1'b1; cfg_sel = sel; cfg_start = s; cfg_end = e;
        cfg_idx = ix; cfg_en = en; cfg_lock = lk;
        @(posedge clk); #1;
        cfg_we = 1'b0; cfg_lock = 1'b0;
        check("cfg_err_pulse", cfg_err_o, err);
        @(posedge clk); #1;
        check("cfg_err_clear", cfg_err_o, 0);
    endtask

    task automatic idle();
        @(posedge clk); #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_dec_valid"}, dec_valid_o, 0);
        check({tag, "_dec_addr"}, dec_addr_o, 0);
        check({tag, "_dec_idx"}, dec_idx_o, 0);
        check({tag, "_dec_hit"}, dec_hit_o, 0);
        check({tag, "_dec_multi"}, dec_multi_o, 0);
        check({tag, "_cfg_err"}, cfg_err_o, 0);
        check({tag, "_miss_cnt"}, miss_cnt_o, 0);
        check({tag, "_req_ready"}, req_ready_o, 1);
    endtask

    // Monitor: a result transfers on the next edge whenever valid && ready.
    initial begin
        forever begin
            @(negedge clk);
            if (dec_valid_o && dec_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("res_addr", dec_addr_o, e.addr);
                    check("res_hit", dec_hit_o, e.hit);
                    check("res_idx", dec_idx_o, e.idx);
                    check("res_multi", dec_multi_o, e.multi);
                end
            end
        end
    end

    initial begin
        @(posedge clk); #1;
        check_all_zero("reset");
        rst = 1'b0;
        idle();

        // Empty table: everything misses.
        send(32'h2000_0004, 0, 0, 0);

        wr(2'd0, 32'h2000_0000, 32'h2000_0010, 4'd0, 1, 0, 0);
        wr(2'd1, 32'h2000_1000, 32'h2000_1100, 4'd1, 1, 0, 0);
        send(32'h2000_1004, 1, 4'd1, 0);
        check("latency_valid", dec_valid_o, 1);
        send(32'h2000_0010, 0, 0, 0);
        send(32'h2000_000F, 1, 4'd0, 0);
        idle();
        check("miss_cnt_2", miss_cnt_o, 16'd2);

        // Rule2 write and a request in the same cycle: decode uses the old table.
        cfg_we = 1'b1; cfg_sel = 2'd2; cfg_start = 32'h2000_0000; cfg_end = 32'h2000_2000;
        cfg_idx = 4'd5; cfg_en = 1'b1;
        req_valid = 1'b1; req_addr = 32'h2000_1800;
        push(32'h2000_1800, 0, 0, 0);
        @(posedge clk); #1;
        cfg_we = 1'b0; req_valid = 1'b0;
        check("same_cycle_wr_err", cfg_err_o, 0);
        send(32'h2000_1800, 1, 4'd5, 0);
        send(32'h2000_0004, 1, 4'd0, 1);
        idle();

        // Backpressure: result held three cycles, then back-to-back throughput.
        dec_ready = 1'b0;
        send(32'h2000_1004, 1, 4'd1, 1);
        req_valid = 1'b1; req_addr = 32'h2000_0008;
        for (int i = 0; i < 3; i++) begin
            check("stall_ready", req_ready_o, 0);
            check("stall_valid", dec_valid_o, 1);
            check("stall_addr", dec_addr_o, 32'h2000_1004);
            check("stall_idx", dec_idx_o, 4'd1);
            check("stall_multi", dec_multi_o, 1);
            idle();
        end
        dec_ready = 1'b1;
        push(32'h2000_0008, 1, 4'd0, 1);
        idle();
        t0 = $time;
        send(32'h2000_3000, 0, 0, 0);
        check("b2b_valid0", dec_valid_o, 1);
        send(32'h2000_1808, 1, 4'd5, 0);
        check("b2b_valid1", dec_valid_o, 1);
        send(32'h2000_000C, 1, 4'd0, 1);
        check("b2b_time", $time - t0, 30);
        idle();

        // Inverted range never matches.
        wr(2'd1, 32'h2000_1100, 32'h2000_1000, 4'd1, 1, 0, 0);
        send(32'h2000_1004, 1, 4'd5, 0);
        send(32'h2000_1100, 1, 4'd5, 0);

        // Out-of-range slot rejected.
        wr(2'd3, 32'h0000_0000, 32'hFFFF_FFFF, 4'd9, 1, 0, 1);
        send(32'h2000_1004, 1, 4'd5, 0);

        // Write with the lock pulse lands; later writes are rejected.
        wr(2'd2, 32'h2000_0000, 32'h2000_2000, 4'd5, 0, 1, 0);
        wr(2'd0, 32'h2000_0000, 32'h2000_0010, 4'd7, 1, 0, 1);
        send(32'h2000_0004, 1, 4'd0, 0);
        send(32'h2000_1004, 0, 0, 0);
        idle();
        check("miss_cnt_5", miss_cnt_o, 16'd5);

        // Saturation.
        force dut.r_miss_cnt = 16'hFFFE;
        #1;
        release dut.r_miss_cnt;
        check("miss_cnt_forced", miss_cnt_o, 16'hFFFE);
        send(32'h1000_0000, 0, 0, 0);
        check("miss_cnt_sat1", miss_cnt_o, 16'hFFFF);
        send(32'h3000_0000, 0, 0, 0);
        send(32'hFFFF_FFFF, 0, 0, 0);
        check("miss_cnt_sat3", miss_cnt_o, 16'hFFFF);
        idle();
        idle();

        // Asynchronous reset with a result in flight.
        dec_ready = 1'b0;
        send(32'h2000_0004, 1, 4'd0, 0);
        check("inflight_valid", dec_valid_o, 1);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        dec_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            idle();
            check("post_rst_no_result", dec_valid_o, 0);
        end
        send(32'h2000_0004, 0, 0, 0);
        check("post_rst_miss_cnt", miss_cnt_o, 16'd1);
        wr(2'd0, 32'h2000_0000, 32'h2000_0010, 4'd0, 1, 0, 0);
        send(32'h2000_0004, 1, 4'd0, 0);

        for (int n = 0; n < 20 && exp_q.size() != 0; n++) idle();
        check("drain", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
